gray_stream_checker: RTL

Downstream consumer of the 4-bit Gray counter/encoder stage. It registers an incoming Gray-coded stream, converts it to binary, and checks that each new sample is a legal single-step move (+1, -1 or hold, modulo 2^WIDTH). It reports step direction, flags illegal transitions, and keeps a saturating error count. Feeds position-tracking and status logic further downstream.

---
 rtl/gray_stream_checker.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/gray_stream_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gray_stream_checker
// Purpose  : Registers a Gray-coded stream, converts to binary and checks
//            every sample is a +1 / -1 / hold move (modulo 2^WIDTH).
//            Optional macro GRAY_POS_ACC_EN enables the signed position
//            accumulator on pos; otherwise pos is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module gray_stream_checker #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int POS_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        g_in,
    input  logic                    g_valid,
    input  logic                    clr,
    output logic [WIDTH-1:0]        b_out,
    output logic                    b_valid,
    output logic                    dir_up,
    output logic                    step_ok,
    output logic                    err_pulse,
    output logic                    fault,
    output logic [ERR_W-1:0]        err_cnt,
    output logic signed [POS_W-1:0] pos
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_g;
    logic             r_gv;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_b;
    logic             r_bv;
    logic             r_dir;
    logic             r_ok;
    logic             r_err;
    logic             r_fault;
    logic [ERR_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic             w_up;
    logic             w_down;
    logic             w_hold;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_bv_nxt;
    logic             w_dir_nxt;
    logic             w_ok_nxt;
    logic             w_err_nxt;
    logic             w_fault_nxt;
    logic [ERR_W-1:0] w_cnt_nxt;

    // Stage 1: input capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g  <= '0;
            r_gv <= 1'b0;
        end else begin
            r_g  <= g_in;
            r_gv <= g_valid;
        end
    end

    // Each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(r_g >> i);
        end
    end

    assign w_delta = w_bin - r_prev;
    assign w_up    = (w_delta == WIDTH'(1));
    assign w_down  = (w_delta == '1);
    assign w_hold  = (w_delta == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_b_nxt     = r_b;
        w_bv_nxt    = 1'b0;
        w_dir_nxt   = r_dir;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_fault_nxt = r_fault;
        w_cnt_nxt   = r_cnt;

        if (clr) begin
            // A coincident sample becomes the new unchecked reference
            w_fault_nxt = 1'b0;
            w_cnt_nxt   = '0;
            if (r_gv) begin
                w_b_nxt     = w_bin;
                w_bv_nxt    = 1'b1;
                w_ok_nxt    = 1'b1;
                w_prev_nxt  = w_bin;
                w_state_nxt = S_LOCKED;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (r_gv) begin
            w_b_nxt    = w_bin;
            w_bv_nxt   = 1'b1;
            w_prev_nxt = w_bin;
            case (r_state)
                S_IDLE: begin
                    w_ok_nxt    = 1'b1;
                    w_state_nxt = S_LOCKED;
                end
                default: begin
                    if (w_up || w_down || w_hold) begin
                        w_ok_nxt = 1'b1;
                        if (w_up) begin
                            w_dir_nxt = 1'b1;
                        end else if (w_down) begin
                            w_dir_nxt = 1'b0;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_FAULT;
                        if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + ERR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Stage 2: check result and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prev  <= '0;
            r_b     <= '0;
            r_bv    <= 1'b0;
            r_dir   <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_b     <= w_b_nxt;
            r_bv    <= w_bv_nxt;
            r_dir   <= w_dir_nxt;
            r_ok    <= w_ok_nxt;
            r_err   <= w_err_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign b_out     = r_b;
    assign b_valid   = r_bv;
    assign dir_up    = r_dir;
    assign step_ok   = r_ok;
    assign err_pulse = r_err;
    assign fault     = r_fault;
    assign err_cnt   = r_cnt;

`ifdef GRAY_POS_ACC_EN
    logic [POS_W-1:0] r_pos;
    logic             w_pos_inc;
    logic             w_pos_dec;

    assign w_pos_inc = r_gv && !clr && (r_state != S_IDLE) && w_up;
    assign w_pos_dec = r_gv && !clr && (r_state != S_IDLE) && w_down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '0;
        end else if (clr) begin
            r_pos <= '0;
        end else if (w_pos_inc) begin
            r_pos <= r_pos + POS_W'(1);
        end else if (w_pos_dec) begin
            r_pos <= r_pos - POS_W'(1);
        end
    end

    assign pos = r_pos;
`else
    assign pos = '0;
`endif

endmodule
`default_nettype wire
